// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: the active-low hex glyph table,
// the all-off anode/segment patterns and the digit index type.
package seg_pkg;

  typedef logic [2:0] digit_idx_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low g..a patterns; entry n is the glyph for nibble value n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  // Index of the highest non-zero nibble, or 0 for an all-zero word.
  function automatic digit_idx_t msd_of(input logic [31:0] word);
    digit_idx_t m;
    m = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (word[k*4 +: 4] != 4'h0) begin
        m = digit_idx_t'(k);
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 8-digit common-anode display driver with per-frame word latch.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [2:0]  digit_idx
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       digit_q, digit_d;
  logic [31:0]      frame_q, frame_d;
  logic [7:0]       dp_frame_q, dp_frame_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic             frame_start_s;
  logic [3:0]       nibble_s;
  logic [6:0]       glyph_s;
  logic [6:0]       glyph_shown_s;

  assign frame_start_s = (digit_q == 3'd0) && (cnt_q == '0);
  assign nibble_s      = frame_q[{digit_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble_i (nibble_s),
    .glyph_o  (glyph_s)
  );

`ifdef SEG_LEADING_ZERO_BLANK_EN
  digit_idx_t msd_q, msd_d;

  always_comb begin
    msd_d = msd_q;
    if (frame_start_s) begin
      msd_d = msd_of(data_in);
    end else begin
      msd_d = msd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msd_q <= 3'd0;
    end else begin
      msd_q <= msd_d;
    end
  end

  // Digit 0 is never blanked because msd is always at least 0.
  assign glyph_shown_s = (digit_q > msd_q) ? GLYPH_BLANK : glyph_s;
`else
  assign glyph_shown_s = glyph_s;
`endif

  always_comb begin
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    frame_d    = frame_q;
    dp_frame_d = dp_frame_q;

    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      digit_d = digit_q + 3'd1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      digit_d = digit_q;
    end

    // Latch a whole frame at once so mid-scan input changes never tear.
    if (frame_start_s) begin
      frame_d    = data_in;
      dp_frame_d = dp_in;
    end else begin
      frame_d    = frame_q;
      dp_frame_d = dp_frame_q;
    end
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (cnt_q < BLANK_LIM) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end else begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = {~dp_frame_q[digit_q], glyph_shown_s};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      digit_q    <= 3'd0;
      frame_q    <= 32'h0;
      dp_frame_q <= 8'h0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      frame_q    <= frame_d;
      dp_frame_q <= dp_frame_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign digit_idx = digit_q;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the display source selector and consumes that selector's 32-bit word. The block latches one word per refresh frame, decodes each nibble to a hex glyph, and scans the digits one at a time. A dead-time gap between digits suppresses ghosting.

## Interface
Parameters:
- `CLK_DIV`, default 50000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, default 500: number of dead-time cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < CLK_DIV.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  asynchronous, active-high reset.
- `data_in`  input  32  word to display; nibble k drives digit k, with digit 0 rightmost.
- `dp_in`  input  8  decimal-point request per digit (1 = lit).
- `an`  output  8  digit anodes, active-low, one-hot-low while a digit is lit.
- `seg`  output  8  segments, active-low; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.
- `digit_idx`  output  3  index of the digit slot currently being driven.

## Operation
- Slot counter `cnt` runs 0..CLK_DIV-1.
  - When `cnt` = CLK_DIV-1, `cnt` wraps to 0 and `digit_idx` increments modulo 8. Digit 7 wraps to digit 0.
- Frame latch: at the clock edge that ends a cycle with `digit_idx`=0 and `cnt`=0, the `frame` register loads `data_in` and the `dp_frame` register loads `dp_in`.
  - Mid-frame changes on `data_in` or `dp_in` are ignored until the next frame, so there is no tearing.
- Output register, updated every edge from the current state:
  - When `cnt` < BLANK_CYCLES: `an` = 8'hFF and `seg` = 8'hFF (dead time).
  - Otherwise: `an` = ~(8'b1 << `digit_idx`), and `seg` = {~dp_frame[digit_idx], glyph(frame nibble digit_idx)}.
- Glyph table, bits 6..0 active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Because BLANK_CYCLES ≥ 1, the first lit cycle of slot 0 always uses the newly latched frame.

## Timing
- Reset, asynchronous on assertion:
  - `cnt`=0, `digit_idx`=0, `frame`=0, `dp_frame`=0.
  - `an`=8'hFF, `seg`=8'hFF.
- The first edge after reset release satisfies the frame-latch condition, so `data_in` is captured immediately.
- `an` and `seg` are registered outputs. They reflect state one cycle late relative to `cnt`.
- Each digit is lit for CLK_DIV-BLANK_CYCLES cycles per slot; the dark portion lasts BLANK_CYCLES cycles.
- Frame period is 8×CLK_DIV cycles.
- Latency from `data_in` to the display is at most 8×CLK_DIV+1 cycles.
- Reset asserted mid-frame blanks the display on assertion. After release the scan restarts at digit 0, `cnt` 0.

## Configuration
- Macro `SEG_LEADING_ZERO_BLANK_EN`.
- When defined:
  - At the frame latch, the block computes `msd` = the index of the highest non-zero nibble of `data_in`, or 0 if the word is zero. This is registered alongside `frame`.
  - Digits with index > `msd` output `seg` = {~dp_frame[k], 7'h7F}. The anode is still driven, and dp is still honoured.
  - Digit 0 is never blanked.
- When undefined: all eight digits always show their glyph. The `msd` logic is absent.

## Structure
- Package `seg_pkg` holds:
  - The 16-entry glyph constant table.
  - `SEG_OFF` = 8'hFF and `AN_OFF` = 8'hFF.
  - Typedef `digit_idx_t` (3-bit).
- Sub-module `hex_to_seg` is a combinational nibble-to-7-bit glyph decoder using the `seg_pkg` table. It is instantiated once, on the selected nibble.

## Test plan
All scenarios use CLK_DIV=4 and BLANK_CYCLES=1.
- Reset: hold `rst` with `data_in`=32'h12345678 → `an`=FF, `seg`=FF. After release, slot 0 lights with `an`=FE, `seg`=80 ('8'), then slot 1 with `an`=FD, `seg`=F8 ('7').
- Full scan: `data_in`=32'hFEDCBA98, `dp_in`=0 → across digits 0..7, `seg` = 80, 90, 88, 83, C6, A1, 86, 8E. Each digit is lit for exactly 3 cycles and preceded by 1 cycle of `an`=FF.
- Tearing: change `data_in` from 32'h0 to 32'h11111111 while `digit_idx`=3 → digits 4..7 still show C0. The next frame shows F9 on all digits.
- Decimal point: `dp_in`=8'h04, `data_in`=0 → digit 2 shows `seg`=40 and all other digits show C0.
- Blanking, with the macro defined: `data_in`=32'h00000A05 → digits 0..2 show 92, C0, 88, and digits 3..7 show FF with their anodes still active. With `data_in`=0, digit 0 shows C0 and the rest show FF.
- Mid-frame reset at `digit_idx`=5 → `an`=FF immediately. After release, the scan resumes at digit 0 with the fresh `data_in`.
